// File: rtl/life_gen_ctrl_if.sv
// Control/data bundle between the life front end, the generation sequencer and the tile.
// master = front end and tile side, slave = life_gen_ctrl.
interface life_gen_ctrl_if #(
  parameter int unsigned GEN_W = 16
);
  logic             load;
  logic [15:0]      load_val;
  logic             start;
  logic             stop;
  logic             single;
  logic [GEN_W-1:0] gen_limit;
  logic [15:0]      alive;
  logic [15:0]      val;
  logic             write_enb;
  logic             step;
  logic             busy;
  logic             done;
  logic [1:0]       stop_cause;
  logic [GEN_W-1:0] gen_count;

  modport master (
    output load, load_val, start, stop, single, gen_limit, alive,
    input  val, write_enb, step, busy, done, stop_cause, gen_count
  );

  modport slave (
    input  load, load_val, start, stop, single, gen_limit, alive,
    output val, write_enb, step, busy, done, stop_cause, gen_count
  );
endinterface

// File: rtl/life_gen_ctrl.sv
// Generation sequencer for the 4x4 life tile: seed load, single step, free run, limit stop.
// Define LIFE_GEN_CTRL_AUTOSTOP_EN to also stop on extinction or still life.
module life_gen_ctrl #(
  parameter int unsigned PERIOD = 16,
  parameter int unsigned GEN_W  = 16
) (
  input logic             clk,
  input logic             reset,
  life_gen_ctrl_if.slave  bus
);

  localparam int unsigned WAIT_W = $clog2(PERIOD);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(PERIOD - 3);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN_WAIT, S_STEP, S_SETTLE, S_DONE
  } state_t;

  state_t           state;
  logic             run_flag;
  logic [WAIT_W-1:0] wait_cnt;
  logic [15:0]      val_q;
  logic             write_enb_q;
  logic             step_q;
  logic             busy_q;
  logic             done_q;
  logic [1:0]       cause_q;
  logic [GEN_W-1:0] gen_q;
  logic [GEN_W-1:0] gen_next;
  logic             stop_hit;
  logic [1:0]       cause_next;
`ifdef LIFE_GEN_CTRL_AUTOSTOP_EN
  logic [15:0]      prev_alive;
`endif

  assign gen_next = (&gen_q) ? gen_q : gen_q + 1'b1;

  // Later assignments override earlier ones, giving extinct > still > limit.
  always_comb begin
    stop_hit   = 1'b0;
    cause_next = 2'b00;
    if ((bus.gen_limit != '0) && (gen_next >= bus.gen_limit)) begin
      stop_hit   = 1'b1;
      cause_next = 2'b01;
    end
`ifdef LIFE_GEN_CTRL_AUTOSTOP_EN
    if (bus.alive == prev_alive) begin
      stop_hit   = 1'b1;
      cause_next = 2'b11;
    end
    if (bus.alive == '0) begin
      stop_hit   = 1'b1;
      cause_next = 2'b10;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      run_flag    <= 1'b0;
      wait_cnt    <= '0;
      val_q       <= '0;
      write_enb_q <= 1'b0;
      step_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cause_q     <= 2'b00;
      gen_q       <= '0;
`ifdef LIFE_GEN_CTRL_AUTOSTOP_EN
      prev_alive  <= '0;
`endif
    end else begin
      write_enb_q <= 1'b0;
      step_q      <= 1'b0;
      if (bus.load) begin
        state       <= S_LOAD;
        val_q       <= bus.load_val;
        write_enb_q <= 1'b1;
        busy_q      <= 1'b1;
        done_q      <= 1'b0;
        cause_q     <= 2'b00;
        gen_q       <= '0;
        run_flag    <= 1'b0;
      end else begin
        if (bus.stop) run_flag <= 1'b0;
        case (state)
          S_IDLE, S_DONE: begin
            if (!bus.stop && (bus.start || bus.single)) begin
              state    <= S_STEP;
              step_q   <= 1'b1;
              busy_q   <= 1'b1;
              done_q   <= 1'b0;
              cause_q  <= 2'b00;
              run_flag <= bus.start;
            end
          end
          S_LOAD: begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
          S_STEP: begin
`ifdef LIFE_GEN_CTRL_AUTOSTOP_EN
            prev_alive <= bus.alive;
`endif
            state <= S_SETTLE;
          end
          S_SETTLE: begin
            gen_q <= gen_next;
            if (stop_hit) begin
              state    <= S_DONE;
              done_q   <= 1'b1;
              cause_q  <= cause_next;
              busy_q   <= 1'b0;
              run_flag <= 1'b0;
            end else if (run_flag && !bus.stop) begin
              state    <= S_RUN_WAIT;
              wait_cnt <= WAIT_INIT;
            end else begin
              state  <= S_IDLE;
              busy_q <= 1'b0;
            end
          end
          S_RUN_WAIT: begin
            if (bus.stop) begin
              state  <= S_IDLE;
              busy_q <= 1'b0;
            end else if (wait_cnt == '0) begin
              state  <= S_STEP;
              step_q <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt - 1'b1;
            end
          end
          default: begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.val        = val_q;
  assign bus.write_enb  = write_enb_q;
  assign bus.step       = step_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.stop_cause = cause_q;
  assign bus.gen_count  = gen_q;

endmodule

// File: tb/tb_life_gen_ctrl.sv
// Directed bench for life_gen_ctrl with a behavioural 4x4 life tile on the feedback path.
module tb_life_gen_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  life_gen_ctrl_if #(.GEN_W(16)) bus ();
  life_gen_ctrl_if #(.GEN_W(4))  bus4 ();

  life_gen_ctrl #(.PERIOD(16), .GEN_W(16)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  life_gen_ctrl #(.PERIOD(3),  .GEN_W(4))  dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 4x4 life with dead border; bit index = col*4 + row.
  function automatic logic [15:0] life_next(input logic [15:0] a);
    logic [15:0] n;
    int cnt;
    n = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        cnt = 0;
        for (int dc = -1; dc <= 1; dc++)
          for (int dr = -1; dr <= 1; dr++)
            if ((dc != 0 || dr != 0) && (c + dc) >= 0 && (c + dc) < 4 && (r + dr) >= 0 && (r + dr) < 4)
              cnt += int'(a[(c + dc) * 4 + r + dr]);
        n[c * 4 + r] = (cnt == 3) || (a[c * 4 + r] && cnt == 2);
      end
    end
    return n;
  endfunction

  logic step_d, step4_d;
  always @(posedge clk) begin
    if (reset) bus.alive <= '0;
    else if (bus.write_enb) bus.alive <= bus.val;
    else if (bus.step && !step_d) bus.alive <= life_next(bus.alive);
    step_d <= bus.step;
  end
  always @(posedge clk) begin
    if (reset) bus4.alive <= '0;
    else if (bus4.write_enb) bus4.alive <= bus4.val;
    else if (bus4.step && !step4_d) bus4.alive <= life_next(bus4.alive);
    step4_d <= bus4.step;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    bus.load_val = v; bus.load = 1'b1; tick(1); bus.load = 1'b0;
  endtask
  task automatic do_start();
    bus.start = 1'b1; tick(1); bus.start = 1'b0;
  endtask
  task automatic do_stop();
    bus.stop = 1'b1; tick(1); bus.stop = 1'b0;
  endtask
  task automatic do_single();
    bus.single = 1'b1; tick(1); bus.single = 1'b0;
  endtask

  initial begin
    int nedge, last, bad_iv, highs;
    logic prev;
    total = 0; bad = 0;
    reset = 1'b1;
    bus.load = 0; bus.load_val = '0; bus.start = 0; bus.stop = 0; bus.single = 0; bus.gen_limit = '0;
    bus4.load = 0; bus4.load_val = '0; bus4.start = 0; bus4.stop = 0; bus4.single = 0; bus4.gen_limit = '0;
    tick(3);
    check("rst_val", 32'(bus.val), 32'h0);
    check("rst_we", 32'(bus.write_enb), 32'h0);
    check("rst_step", 32'(bus.step), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_cause", 32'(bus.stop_cause), 32'h0);
    check("rst_gen", 32'(bus.gen_count), 32'h0);
    reset = 1'b0;
    tick(1);

    // Blinker run with limit 5
    bus.gen_limit = 16'd5;
    do_load(16'h0070);
    check("t2_we_hi", 32'(bus.write_enb), 32'h1);
    check("t2_val", 32'(bus.val), 32'h0070);
    check("t2_busy_load", 32'(bus.busy), 32'h1);
    tick(1);
    check("t2_we_lo", 32'(bus.write_enb), 32'h0);
    check("t2_alive_seed", 32'(bus.alive), 32'h0070);
    check("t2_busy_idle", 32'(bus.busy), 32'h0);
    do_start();
    check("t2_first_step", 32'(bus.step), 32'h1);
    nedge = 0; last = -1; bad_iv = 0; prev = 1'b0;
    for (int i = 0; i < 200 && !bus.done; i++) begin
      if (bus.step && !prev) begin
        if (last >= 0 && (i - last) != 16) bad_iv++;
        last = i;
        nedge++;
      end
      prev = bus.step;
      tick(1);
    end
    check("t2_done", 32'(bus.done), 32'h1);
    check("t2_edges", 32'(nedge), 32'd5);
    check("t2_spacing_errs", 32'(bad_iv), 32'd0);
    check("t2_gen", 32'(bus.gen_count), 32'd5);
    check("t2_cause", 32'(bus.stop_cause), 32'h1);
    check("t2_busy", 32'(bus.busy), 32'h0);
    check("t2_alive", 32'(bus.alive), 32'h0222);
    tick(5);
    check("t2_held_done", 32'(bus.done), 32'h1);
    check("t2_held_gen", 32'(bus.gen_count), 32'd5);
    do_start();
    check("t2_restart_done_clr", 32'(bus.done), 32'h0);
    tick(2);
    check("t2_restart_done", 32'(bus.done), 32'h1);
    check("t2_restart_gen", 32'(bus.gen_count), 32'd6);
    check("t2_restart_cause", 32'(bus.stop_cause), 32'h1);

    // Block still life, limit 1: still-life cause outranks limit
    bus.gen_limit = 16'd1;
    do_load(16'h0033);
    check("t3_load_done_clr", 32'(bus.done), 32'h0);
    check("t3_load_gen_clr", 32'(bus.gen_count), 32'h0);
    tick(1);
    do_start();
    tick(2);
    check("t3_done", 32'(bus.done), 32'h1);
    check("t3_gen", 32'(bus.gen_count), 32'd1);
    check("t3_alive", 32'(bus.alive), 32'h0033);
`ifdef LIFE_GEN_CTRL_AUTOSTOP_EN
    check("t3_cause", 32'(bus.stop_cause), 32'h3);
`else
    check("t3_cause", 32'(bus.stop_cause), 32'h1);
`endif

    // Single step of a lone cell
    bus.gen_limit = '0;
    do_load(16'h0001);
    tick(1);
    do_single();
    check("t4_step", 32'(bus.step), 32'h1);
    tick(2);
    check("t4_gen", 32'(bus.gen_count), 32'd1);
    check("t4_alive", 32'(bus.alive), 32'h0);
    check("t4_busy", 32'(bus.busy), 32'h0);
`ifdef LIFE_GEN_CTRL_AUTOSTOP_EN
    check("t4_done", 32'(bus.done), 32'h1);
    check("t4_cause", 32'(bus.stop_cause), 32'h2);
`else
    check("t4_done", 32'(bus.done), 32'h0);
    check("t4_cause", 32'(bus.stop_cause), 32'h0);
`endif
    tick(20);
    check("t4_gen_hold", 32'(bus.gen_count), 32'd1);

    // Stop during STEP, stop during RUN_WAIT, load beats start
    do_load(16'h0070);
    tick(1);
    do_start();
    bus.stop = 1'b1; tick(1); bus.stop = 1'b0;
    tick(1);
    check("t5_gen", 32'(bus.gen_count), 32'd1);
    check("t5_busy", 32'(bus.busy), 32'h0);
    check("t5_done", 32'(bus.done), 32'h0);
    check("t5_cause", 32'(bus.stop_cause), 32'h0);
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.step) highs++;
      tick(1);
    end
    check("t5_no_more_steps", 32'(highs), 32'd0);
    do_start();
    tick(2);
    check("t5_rw_busy", 32'(bus.busy), 32'h1);
    do_stop();
    check("t5_rw_stop_busy", 32'(bus.busy), 32'h0);
    check("t5_rw_stop_gen", 32'(bus.gen_count), 32'd2);
    check("t5_rw_stop_done", 32'(bus.done), 32'h0);
    bus.load_val = 16'h0222; bus.load = 1'b1; bus.start = 1'b1;
    tick(1);
    bus.load = 1'b0; bus.start = 1'b0;
    check("t5_ls_we", 32'(bus.write_enb), 32'h1);
    check("t5_ls_step", 32'(bus.step), 32'h0);
    check("t5_ls_gen", 32'(bus.gen_count), 32'h0);
    tick(1);
    check("t5_ls_idle_busy", 32'(bus.busy), 32'h0);
    check("t5_ls_idle_step", 32'(bus.step), 32'h0);

    // Asynchronous reset in RUN_WAIT and in STEP
    do_load(16'h0070);
    tick(1);
    do_start();
    tick(4);
    check("t1_rw_busy", 32'(bus.busy), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("t1_rw_val", 32'(bus.val), 32'h0);
    check("t1_rw_busy0", 32'(bus.busy), 32'h0);
    check("t1_rw_gen", 32'(bus.gen_count), 32'h0);
    check("t1_rw_done", 32'(bus.done), 32'h0);
    #1 reset = 1'b0;
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bus.step || bus.busy) highs++;
    end
    check("t1_rw_stays_idle", 32'(highs), 32'd0);
    do_start();
    check("t1_st_step", 32'(bus.step), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("t1_st_step0", 32'(bus.step), 32'h0);
    check("t1_st_busy0", 32'(bus.busy), 32'h0);
    check("t1_st_cause", 32'(bus.stop_cause), 32'h0);
    check("t1_st_we", 32'(bus.write_enb), 32'h0);
    #1 reset = 1'b0;
    tick(3);
    check("t1_st_idle_busy", 32'(bus.busy), 32'h0);
    check("t1_st_idle_step", 32'(bus.step), 32'h0);
    check("t1_st_idle_gen", 32'(bus.gen_count), 32'h0);

    // GEN_W=4, PERIOD=3: saturation with unlimited run
    bus4.load_val = 16'h0070; bus4.load = 1'b1; tick(1); bus4.load = 1'b0;
    tick(1);
    bus4.start = 1'b1; tick(1); bus4.start = 1'b0;
    nedge = 0; last = -1; bad_iv = 0; prev = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus4.step && !prev) begin
        if (last >= 0 && (i - last) != 3) bad_iv++;
        last = i;
        nedge++;
      end
      prev = bus4.step;
      tick(1);
    end
    check("t6_edges", 32'(nedge), 32'd20);
    check("t6_spacing_errs", 32'(bad_iv), 32'd0);
    check("t6_gen_sat", 32'(bus4.gen_count), 32'hF);
    check("t6_busy", 32'(bus4.busy), 32'h1);
    check("t6_done", 32'(bus4.done), 32'h0);
    tick(9);
    check("t6_gen_sat_hold", 32'(bus4.gen_count), 32'hF);
    bus4.stop = 1'b1; tick(1); bus4.stop = 1'b0;
    tick(3);
    check("t6_stopped", 32'(bus4.busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
